// File: rtl/snake_engine.sv
// Grid snake engine: body cells live in a ring buffer mirrored by an occupancy bitmap.
// One move per tick with wall/self collision; render queries answer from the bitmap.
module snake_engine #(
    parameter int MAX_LEN = 64,
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int START_X = 10,
    parameter int START_Y = 10,
    parameter bit WRAP    = 1'b0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     tick,
    input  logic [3:0]               dir_req,
    input  logic                     grow,
    input  logic [X_W-1:0]           query_x,
    input  logic [Y_W-1:0]           query_y,
    output logic                     occ_hit,
    output logic                     head_hit,
    output logic [X_W-1:0]           head_x,
    output logic [Y_W-1:0]           head_y,
    output logic [$clog2(MAX_LEN):0] length,
    output logic                     alive,
    output logic                     dead,
    output logic                     step_done
);
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);
    localparam int XY_W  = X_W + Y_W;

    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0001;

    typedef enum logic [2:0] {IDLE, RUN, CALC, COMMIT, DEAD} state_t;

    function automatic logic in_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < GRID_W) && (int'(y) < GRID_H);
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return IDX_W'(int'(y) * GRID_W + int'(x));
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         dir_q, dir_d;
    logic               grow_pend_q, grow_pend_d;
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [X_W-1:0]     head_x_q, head_x_d, next_x_q, next_x_d, calc_x;
    logic [Y_W-1:0]     head_y_q, head_y_d, next_y_q, next_y_d, calc_y;
    logic               wall_q, wall_d, next_occ_q, next_occ_d, calc_wall;
    logic               step_done_q, step_done_d;
    logic               occ_hit_q, occ_hit_d, head_hit_q, head_hit_d;
    logic [CELLS-1:0]   bitmap_q, bitmap_d;
    logic [XY_W-1:0]    ring_q [MAX_LEN];
    logic               ring_we;
    logic [PTR_W-1:0]   ring_waddr;
    logic [XY_W-1:0]    ring_wdata, tail_cell;
    logic [3:0]         dir_rev;
    logic               dir_valid, grow_ok, tail_hit, collide;

    assign alive     = (state_q == RUN) || (state_q == CALC) || (state_q == COMMIT);
    assign dead      = (state_q == DEAD);
    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign length    = length_q;
    assign step_done = step_done_q;
    assign occ_hit   = occ_hit_q;
    assign head_hit  = head_hit_q;

    // Direction order is {right,down,left,up}, so the reverse swaps the two bit pairs.
    assign dir_rev   = {dir_q[1], dir_q[0], dir_q[3], dir_q[2]};
    assign dir_valid = (dir_req != 4'b0) && ((dir_req & (dir_req - 4'd1)) == 4'b0) && (dir_req != dir_rev);

    assign tail_cell = ring_q[tail_ptr_q];
    assign grow_ok   = grow_pend_q && (length_q < LEN_W'(MAX_LEN));
    assign tail_hit  = (tail_cell == {next_x_q, next_y_q});
    assign collide   = wall_q || (next_occ_q && !(tail_hit && !grow_ok));

    // Edge checks happen before the arithmetic so nothing relies on unsigned wraparound.
    always_comb begin
        calc_x    = head_x_q;
        calc_y    = head_y_q;
        calc_wall = 1'b0;
        if (dir_q == DIR_UP) begin
            if (head_y_q == '0) begin
                if (WRAP) calc_y = Y_W'(GRID_H - 1);
                else      calc_wall = 1'b1;
            end else calc_y = head_y_q - 1'b1;
        end else if (dir_q == DIR_DOWN) begin
            if (head_y_q == Y_W'(GRID_H - 1)) begin
                if (WRAP) calc_y = '0;
                else      calc_wall = 1'b1;
            end else calc_y = head_y_q + 1'b1;
        end else if (dir_q == DIR_LEFT) begin
            if (head_x_q == '0) begin
                if (WRAP) calc_x = X_W'(GRID_W - 1);
                else      calc_wall = 1'b1;
            end else calc_x = head_x_q - 1'b1;
        end else begin
            if (head_x_q == X_W'(GRID_W - 1)) begin
                if (WRAP) calc_x = '0;
                else      calc_wall = 1'b1;
            end else calc_x = head_x_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        grow_pend_d = grow_pend_q;
        head_ptr_d  = head_ptr_q;
        tail_ptr_d  = tail_ptr_q;
        length_d    = length_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        bitmap_d    = bitmap_q;
        next_x_d    = next_x_q;
        next_y_d    = next_y_q;
        wall_d      = wall_q;
        next_occ_d  = next_occ_q;
        step_done_d = 1'b0;
        ring_we     = 1'b0;
        ring_waddr  = head_ptr_q;
        ring_wdata  = {next_x_q, next_y_q};

        occ_hit_d  = in_grid(query_x, query_y) && bitmap_q[cell_idx(query_x, query_y)];
        head_hit_d = (state_q != IDLE) && in_grid(query_x, query_y) &&
                     (query_x == head_x_q) && (query_y == head_y_q);

        if (dir_valid) dir_d = dir_req;
        if (grow && alive) grow_pend_d = 1'b1;

        if (start) begin
            state_d     = RUN;
            dir_d       = DIR_RIGHT;
            grow_pend_d = 1'b0;
            head_ptr_d  = '0;
            tail_ptr_d  = '0;
            length_d    = LEN_W'(1);
            head_x_d    = X_W'(START_X);
            head_y_d    = Y_W'(START_Y);
            bitmap_d    = '0;
            bitmap_d[cell_idx(X_W'(START_X), Y_W'(START_Y))] = 1'b1;
            ring_we     = 1'b1;
            ring_waddr  = '0;
            ring_wdata  = {X_W'(START_X), Y_W'(START_Y)};
        end else begin
            case (state_q)
                RUN: if (tick) state_d = CALC;
                CALC: begin
                    next_x_d   = calc_x;
                    next_y_d   = calc_y;
                    wall_d     = calc_wall;
                    next_occ_d = bitmap_q[cell_idx(calc_x, calc_y)];
                    state_d    = COMMIT;
                end
                COMMIT: begin
                    // A grow pulse landing on the commit cycle carries over to the next move.
                    grow_pend_d = grow;
                    if (collide) begin
                        state_d = DEAD;
                    end else begin
                        head_ptr_d = head_ptr_q + 1'b1;
                        ring_we    = 1'b1;
                        ring_waddr = head_ptr_q + 1'b1;
                        head_x_d   = next_x_q;
                        head_y_d   = next_y_q;
                        if (grow_ok) begin
                            length_d = length_q + 1'b1;
                        end else begin
                            bitmap_d[cell_idx(tail_cell[XY_W-1:Y_W], tail_cell[Y_W-1:0])] = 1'b0;
                            tail_ptr_d = tail_ptr_q + 1'b1;
                        end
                        bitmap_d[cell_idx(next_x_q, next_y_q)] = 1'b1;
                        step_done_d = 1'b1;
                        state_d     = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            dir_q       <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            head_ptr_q  <= '0;
            tail_ptr_q  <= '0;
            length_q    <= '0;
            head_x_q    <= X_W'(START_X);
            head_y_q    <= Y_W'(START_Y);
            bitmap_q    <= '0;
            next_x_q    <= '0;
            next_y_q    <= '0;
            wall_q      <= 1'b0;
            next_occ_q  <= 1'b0;
            step_done_q <= 1'b0;
            occ_hit_q   <= 1'b0;
            head_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            grow_pend_q <= grow_pend_d;
            head_ptr_q  <= head_ptr_d;
            tail_ptr_q  <= tail_ptr_d;
            length_q    <= length_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            bitmap_q    <= bitmap_d;
            next_x_q    <= next_x_d;
            next_y_q    <= next_y_d;
            wall_q      <= wall_d;
            next_occ_q  <= next_occ_d;
            step_done_q <= step_done_d;
            occ_hit_q   <= occ_hit_d;
            head_hit_q  <= head_hit_d;
        end
    end

    // Ring contents need no reset: only entries between tail and head are ever read.
    always_ff @(posedge clk) begin
        if (resetn && ring_we) ring_q[ring_waddr] <= ring_wdata;
    end
endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a no-wrap 64-segment instance and a wrapping 8-segment instance
// share stimulus; a queue-of-segments model predicts every move and render query.
module tb_snake_engine;
    localparam logic [3:0] RIGHT = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b0010;
    localparam logic [3:0] UP    = 4'b0001;
    localparam int GW = 40, GH = 30, SX = 10, SY = 10;

    logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, tick = 1'b0, grow = 1'b0;
    logic [3:0] dir_req = 4'b0;
    logic [5:0] query_x = 6'd0;
    logic [4:0] query_y = 5'd0;

    logic       occ0, hh0, alive0, dead0, sd0;
    logic [5:0] hx0;
    logic [4:0] hy0;
    logic [6:0] len0;
    logic       occ1, hh1, alive1, dead1, sd1;
    logic [5:0] hx1;
    logic [4:0] hy1;
    logic [3:0] len1;

    always #5 clk = ~clk;

    snake_engine #(.MAX_LEN(64), .WRAP(1'b0)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick), .dir_req(dir_req), .grow(grow),
        .query_x(query_x), .query_y(query_y), .occ_hit(occ0), .head_hit(hh0), .head_x(hx0),
        .head_y(hy0), .length(len0), .alive(alive0), .dead(dead0), .step_done(sd0));

    snake_engine #(.MAX_LEN(8), .WRAP(1'b1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick), .dir_req(dir_req), .grow(grow),
        .query_x(query_x), .query_y(query_y), .occ_hit(occ1), .head_hit(hh1), .head_x(hx1),
        .head_y(hy1), .length(len1), .alive(alive1), .dead(dead1), .step_done(sd1));

    int errors = 0, checks = 0, sd_cnt = 0;
    logic [31:0] exp_q0[$], exp_q1[$], qry_q[$];

    // Reference model: segment list with index 0 as head.
    int         mlen [2];
    logic [5:0] mx [2][64];
    logic [4:0] my [2][64];
    logic [3:0] mdir [2];
    bit         mgrow [2], malive [2], mdead [2];

    always @(posedge clk) if (sd0) sd_cnt <= sd_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int max_len(input int i);
        return (i == 0) ? 64 : 8;
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        logic [3:0] r;
        r = 4'b0;
        case (d)
            RIGHT: r = LEFT;
            LEFT:  r = RIGHT;
            UP:    r = DOWN;
            DOWN:  r = UP;
            default: r = 4'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int i, input bit sd);
        logic [5:0] hx;
        logic [4:0] hy;
        hx = (mlen[i] > 0) ? mx[i][0] : 6'(SX);
        hy = (mlen[i] > 0) ? my[i][0] : 5'(SY);
        return {10'b0, sd, mdead[i], malive[i], hx, hy, 8'(mlen[i])};
    endfunction

    function automatic logic [31:0] obs_word(input int i);
        if (i == 0) return {10'b0, sd0, dead0, alive0, hx0, hy0, 8'(len0)};
        return {10'b0, sd1, dead1, alive1, hx1, hy1, 8'(len1)};
    endfunction

    function automatic bit m_occ(input int i, input int x, input int y);
        for (int k = 0; k < mlen[i]; k++)
            if (int'(mx[i][k]) == x && int'(my[i][k]) == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_head(input int i, input int x, input int y);
        return (mlen[i] > 0) && int'(mx[i][0]) == x && int'(my[i][0]) == y;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mlen[i] = 0; mdir[i] = RIGHT; mgrow[i] = 1'b0; malive[i] = 1'b0; mdead[i] = 1'b0;
        end
    endtask

    task automatic model_start();
        for (int i = 0; i < 2; i++) begin
            mlen[i] = 1; mx[i][0] = 6'(SX); my[i][0] = 5'(SY);
            mdir[i] = RIGHT; mgrow[i] = 1'b0; malive[i] = 1'b1; mdead[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] d, input bit g);
        int nx, ny;
        bit wall, hit, eg, sd;
        sd = 1'b0;
        if ($countones(d) == 1 && d != opposite(mdir[i])) mdir[i] = d;
        if (malive[i]) begin
            if (g) mgrow[i] = 1'b1;
            nx = int'(mx[i][0]);
            ny = int'(my[i][0]);
            case (mdir[i])
                RIGHT:   nx = nx + 1;
                DOWN:    ny = ny + 1;
                LEFT:    nx = nx - 1;
                default: ny = ny - 1;
            endcase
            wall = 1'b0;
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                if (i == 1) begin
                    nx = (nx + GW) % GW;
                    ny = (ny + GH) % GH;
                end else wall = 1'b1;
            end
            eg = mgrow[i] && (mlen[i] < max_len(i));
            hit = 1'b0;
            for (int k = 0; k < mlen[i]; k++)
                if ((k < mlen[i] - 1 || eg) && int'(mx[i][k]) == nx && int'(my[i][k]) == ny) hit = 1'b1;
            mgrow[i] = 1'b0;
            if (wall || hit) begin
                malive[i] = 1'b0;
                mdead[i]  = 1'b1;
            end else begin
                if (eg) mlen[i] = mlen[i] + 1;
                for (int k = mlen[i] - 1; k > 0; k--) begin
                    mx[i][k] = mx[i][k-1];
                    my[i][k] = my[i][k-1];
                end
                mx[i][0] = 6'(nx);
                my[i][0] = 5'(ny);
                sd = 1'b1;
            end
        end
        if (i == 0) exp_q0.push_back(exp_word(0, sd));
        else        exp_q1.push_back(exp_word(1, sd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; start = 1'b0; tick = 1'b0; grow = 1'b0; dir_req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check("reset0", obs_word(0), exp_word(0, 1'b0));
        check("reset1", obs_word(1), exp_word(1, 1'b0));
        resetn = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1; dir_req = 4'b0;
        @(negedge clk);
        start = 1'b0;
        model_start();
        check("start0", obs_word(0), exp_word(0, 1'b0));
        check("start1", obs_word(1), exp_word(1, 1'b0));
    endtask

    // tick is sampled at edge k; the move must show at edge k+2 and the pulse must last one cycle.
    task automatic step(input logic [3:0] d, input bit g, input bit hold);
        @(negedge clk);
        dir_req = d; grow = g; tick = 1'b1;
        model_step(0, d, g);
        model_step(1, d, g);
        @(negedge clk);
        dir_req = 4'b0; grow = 1'b0; tick = hold;
        check("sd_calc", 32'({sd0, sd1}), 32'(0));
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        if (exp_q0.size() == 0 || exp_q1.size() == 0) check("exp_queue_empty", 32'(1), 32'(0));
        else begin
            check("step0", obs_word(0), exp_q0.pop_front());
            check("step1", obs_word(1), exp_q1.pop_front());
        end
        @(negedge clk);
        check("sd_one_cycle", 32'({sd0, sd1}), 32'(0));
    endtask

    task automatic query(input int x, input int y);
        logic [5:0] qx;
        logic [4:0] qy;
        qx = 6'(x);
        qy = 5'(y);
        @(negedge clk);
        query_x = qx; query_y = qy;
        qry_q.push_back(32'({m_occ(0, int'(qx), int'(qy)), m_head(0, int'(qx), int'(qy)),
                             m_occ(1, int'(qx), int'(qy)), m_head(1, int'(qx), int'(qy))}));
        @(negedge clk);
        check("query", 32'({occ0, hh0, occ1, hh1}), qry_q.pop_front());
    endtask

    initial begin
        int c;
        logic [3:0] rd;

        // Reset state and an empty IDLE query (head register holds START but must not hit).
        do_reset();
        query(SX, SY);

        // Three plain moves right from the start cell.
        do_start();
        c = sd_cnt;
        repeat (3) step(4'b0, 1'b0, 1'b0);
        check("sd_count", 32'(sd_cnt - c), 32'(3));
        query(13, 10);
        query(12, 10);

        // Reversal and multi-hot requests are ignored.
        step(LEFT, 1'b0, 1'b0);
        step(UP | LEFT, 1'b0, 1'b0);

        // Growth, then saturation at the 8-segment instance.
        do_start();
        step(4'b0, 1'b1, 1'b0);
        query(10, 10);
        query(11, 10);
        repeat (7) step(4'b0, 1'b1, 1'b0);
        query(10, 10);

        // Right-hand wall at row 5: no-wrap instance dies, wrap instance reappears at x=0.
        do_start();
        repeat (5) step(UP, 1'b0, 1'b0);
        repeat (29) step(RIGHT, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b0);
        query(39, 5);
        query(0, 5);
        step(DOWN, 1'b0, 1'b0);

        // Length-5 body turned into itself.
        do_start();
        repeat (4) step(4'b0, 1'b1, 1'b0);
        step(UP, 1'b0, 1'b0);
        step(LEFT, 1'b0, 1'b0);
        step(DOWN, 1'b0, 1'b0);

        // Length-4 square loop repeatedly entering the vacating tail cell.
        do_start();
        step(RIGHT, 1'b1, 1'b0);
        step(DOWN, 1'b1, 1'b0);
        step(LEFT, 1'b1, 1'b0);
        repeat (2) begin
            step(UP, 1'b0, 1'b0);
            step(RIGHT, 1'b0, 1'b0);
            step(DOWN, 1'b0, 1'b0);
            step(LEFT, 1'b0, 1'b0);
        end
        query(10, 10);
        query(11, 11);

        // Reset landing on the commit cycle wins over the move.
        do_start();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_commit0", obs_word(0), exp_word(0, 1'b0));
        check("rst_commit1", obs_word(1), exp_word(1, 1'b0));
        resetn = 1'b1;
        query(10, 10);
        query(11, 10);
        query(39, 29);

        // A tick held into CALC is dropped: exactly one move.
        do_start();
        step(4'b0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b0);
        query(12, 10);
        query(63, 31);

        // Random walk with occasional growth and mixed queries.
        do_start();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) rd = 4'($urandom_range(0, 15));
            else rd = 4'(1 << $urandom_range(0, 3));
            step(rd, ($urandom_range(0, 3) == 0), 1'b0);
            if (n % 5 == 4) begin
                query($urandom_range(0, 47), $urandom_range(0, 31));
                query(int'(mx[0][0]), int'(my[0][0]));
                query(int'(mx[1][0]), int'(my[1][0]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
